// File: rtl/fmul_arbiter.sv
// ---------------------------------------------------------------------------
// fmul_arbiter
//   Shares one single-precision floating multiplier between N requesters.
//   Round-robin grant (at most one issue per clock), registered operands to
//   the multiplier, and the result returned tagged with the requester id.
//
// Ports
//   clk        clock, all state on posedge
//   reset_n    asynchronous active-low reset
//   req_valid  [N]      requester i has an operand pair
//   req_a/b    [32*N]   operand pairs, requester i in bits [32i+31:32i]
//   req_ready  [N]      one-hot grant (handshake = req_valid & req_ready)
//   hold                block new grants; in-flight ops still complete
//   mul_a/b    [32]     registered operands to the multiplier
//   mul_out    [32]     multiplier result
//   rsp_valid           one-cycle result pulse
//   rsp_id     [IDW]    owner of the result
//   rsp_data   [32]     product, copied unmodified from mul_out
//   busy                an op is in flight or rsp_valid is high
//   op_count   [16]     accepted ops, wrapping
// ---------------------------------------------------------------------------
module fmul_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = $clog2(N),
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N-1:0]      req_valid,
    input  logic [32*N-1:0]   req_a,
    input  logic [32*N-1:0]   req_b,
    output logic [N-1:0]      req_ready,
    input  logic              hold,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_out,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_data,
    output logic              busy,
    output logic [15:0]       op_count
);

    logic [IDW-1:0]             r_ptr;
    logic [31:0]                r_mul_a;
    logic [31:0]                r_mul_b;
    logic [15:0]                r_op_count;
    // Stage 0 loads together with r_mul_a/b; stage MUL_LAT is aligned with
    // the cycle in which mul_out carries that op's product.
    logic [MUL_LAT:0]           r_pipe_vld;
    logic [MUL_LAT:0][IDW-1:0]  r_pipe_id;
    logic                       r_rsp_valid;
    logic [IDW-1:0]             r_rsp_id;
    logic [31:0]                r_rsp_data;

    logic                       w_found;
    logic [IDW-1:0]             w_gid;
    logic [N-1:0]               w_grant;
    logic                       w_hs;
    logic [IDW-1:0]             w_ptr_nxt;

    // Rotating priority scan: ptr, ptr+1, ..., wrapping at N.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % N]) begin
                w_found = 1'b1;
                w_gid   = IDW'((int'(r_ptr) + k) % N);
            end
        end
    end

    // Grant is suppressed while held or while reset is asserted.
    always_comb begin
        w_grant = '0;
        if (w_found && !hold && reset_n)
            w_grant[w_gid] = 1'b1;
    end

    assign w_hs      = |w_grant;
    assign w_ptr_nxt = (w_gid == IDW'(N - 1)) ? '0 : w_gid + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_op_count <= '0;
        end else if (w_hs) begin
            r_ptr      <= w_ptr_nxt;
            r_mul_a    <= req_a[32*int'(w_gid) +: 32];
            r_mul_b    <= req_b[32*int'(w_gid) +: 32];
            r_op_count <= r_op_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_pipe_vld <= {r_pipe_vld[MUL_LAT-1:0], w_hs};
            r_pipe_id[0] <= w_gid;
            for (int s = 1; s <= MUL_LAT; s++)
                r_pipe_id[s] <= r_pipe_id[s-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else if (r_pipe_vld[MUL_LAT]) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_pipe_id[MUL_LAT];
            r_rsp_data  <= mul_out;
        end else begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign req_ready = w_grant;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign op_count  = r_op_count;
    assign busy      = (|r_pipe_vld) | r_rsp_valid;

endmodule

// File: tb/tb_fmul_arbiter.sv
module tb_fmul_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0][31:0]   req_a;
    logic [N-1:0][31:0]   req_b;
    logic [N-1:0]         req_ready;
    logic                 hold;
    logic [31:0]          mul_a, mul_b, mul_out;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_data;
    logic                 busy;
    logic [15:0]          op_count;

    int n_tests = 0;
    int n_fail  = 0;
    int rsp_cnt = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [IDW-1:0] pre;   // requester issued first; leaves ptr = pre+1
        logic [N-1:0]   vld;
        logic           hld;
        logic [N-1:0]   exp_rdy;
    } arb_vec_t;

    fmul_arbiter #(.N(N), .IDW(IDW), .MUL_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .hold(hold),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: exact products for the known IEEE cases, an
    // asymmetric scramble otherwise so a wrong operand slice is visible.
    function automatic logic [31:0] fmul_model(logic [31:0] a, logic [31:0] b);
        if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
        if (a == 32'hC0000000 && b == 32'h40400000) return 32'hC0C00000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
    endfunction

    // One-cycle-latency multiplier.
    initial mul_out = '0;
    always @(posedge clk) mul_out <= fmul_model(mul_a, mul_b);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard: push on handshake, pop on response.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i])
                    sb_q.push_back('{id: IDW'(i), data: fmul_model(req_a[i], req_b[i])});
            if (rsp_valid) begin
                rsp_cnt++;
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_unexpected: got id %0d data %h expected no response", rsp_id, rsp_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_id", 32'(rsp_id), 32'(e.id));
                    check("sb_data", rsp_data, e.data);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_ops(input int seed);
        for (int i = 0; i < N; i++) begin
            req_a[i] = {8'(i + 1), 24'(seed)};
            req_b[i] = {24'(seed * 3 + 1), 8'(i + 7)};
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req_valid = '0; hold = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 30; c++) begin
            if (!busy && sb_q.size() == 0) break;
            step();
        end
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_q"}, 32'(sb_q.size()), 32'd0);
    endtask

    arb_vec_t vt[9];
    int cnt0;

    initial begin
        vt[0] = '{pre: 2'd3, vld: 4'b1111, hld: 1'b0, exp_rdy: 4'b0001};
        vt[1] = '{pre: 2'd0, vld: 4'b1111, hld: 1'b0, exp_rdy: 4'b0010};
        vt[2] = '{pre: 2'd1, vld: 4'b0011, hld: 1'b0, exp_rdy: 4'b0001};
        vt[3] = '{pre: 2'd2, vld: 4'b0110, hld: 1'b0, exp_rdy: 4'b0010};
        vt[4] = '{pre: 2'd3, vld: 4'b1000, hld: 1'b0, exp_rdy: 4'b1000};
        vt[5] = '{pre: 2'd0, vld: 4'b0000, hld: 1'b0, exp_rdy: 4'b0000};
        vt[6] = '{pre: 2'd1, vld: 4'b1111, hld: 1'b1, exp_rdy: 4'b0000};
        vt[7] = '{pre: 2'd2, vld: 4'b1001, hld: 1'b0, exp_rdy: 4'b1000};
        vt[8] = '{pre: 2'd0, vld: 4'b0001, hld: 1'b0, exp_rdy: 4'b0001};

        reset_n = 1'b0; req_valid = '0; hold = 1'b0; set_ops(0);
        #12;
        // Reset state
        req_valid = 4'b1111; #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_mul_a", mul_a, 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        @(posedge clk); #1 reset_n = 1'b1;

        // 1: single op 2.0*3.0, latency 2
        step();
        req_a[0] = 32'h40000000; req_b[0] = 32'h40400000; req_valid = 4'b0001; #1;
        check("t1_ready", 32'(req_ready), 32'b0001);
        step(); req_valid = '0;
        check("t1_op_count", 32'(op_count), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_rsp_early", 32'(rsp_valid), 32'd0);
        step();
        check("t1_rsp_not_yet", 32'(rsp_valid), 32'd0);
        step();
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_id", 32'(rsp_id), 32'd0);
        check("t1_rsp_data", rsp_data, 32'h40C00000);
        step();
        check("t1_pulse_end", 32'(rsp_valid), 32'd0);
        drain("t1");

        // Arbitration table
        for (int v = 0; v < 9; v++) begin
            step();
            set_ops(100 + v);
            req_valid = '0; req_valid[vt[v].pre] = 1'b1; hold = 1'b0;
            step();
            req_valid = vt[v].vld; hold = vt[v].hld; #1;
            check($sformatf("arb_vec%0d", v), 32'(req_ready), 32'(vt[v].exp_rdy));
            #1 req_valid = '0; hold = 1'b0;
        end
        drain("arb");

        // 2: all requesters valid for 8 cycles from ptr=0
        do_reset();
        cnt0 = rsp_cnt;
        step(); set_ops(7); req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1 check($sformatf("t2_grant%0d", c), 32'(req_ready), 32'(4'b0001 << (c % 4)));
            set_ops(20 + c);
            step();
        end
        req_valid = '0;
        drain("t2");
        check("t2_pulses", 32'(rsp_cnt - cnt0), 32'd8);

        // 3: ptr=3 with req2 and req3 pending -> req3 first
        step(); set_ops(55); req_valid = 4'b0100;
        step(); req_valid = '0;
        req_a[2] = 32'h3FC00000; req_b[2] = 32'h3FC00000;
        req_a[3] = 32'hC0000000; req_b[3] = 32'h40400000;
        req_valid = 4'b1100; #1;
        check("t3_first", 32'(req_ready), 32'b1000);
        step(); req_valid = 4'b0100; #1;
        check("t3_second", 32'(req_ready), 32'b0100);
        step(); req_valid = '0;
        step(); step();
        check("t3_last_id", 32'(rsp_id), 32'd2);
        check("t3_last_data", rsp_data, 32'h40100000);
        drain("t3");

        // 4: hold with one op in flight
        step(); set_ops(77); req_valid = 4'b0001;
        step(); req_valid = 4'b0010; hold = 1'b1; #1;
        check("t4_hold_rdy", 32'(req_ready), 32'd0);
        check("t4_busy_inflight", 32'(busy), 32'd1);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("t4_hold_rdy%0d", c), 32'(req_ready), 32'd0);
        end
        check("t4_busy_drop", 32'(busy), 32'd0);
        check("t4_drained", 32'(sb_q.size()), 32'd0);
        hold = 1'b0; #1;
        check("t4_release", 32'(req_ready), 32'b0010);
        step(); req_valid = '0;
        drain("t4");

        // 5: reset one cycle after a handshake discards the op
        step(); set_ops(88); req_valid = 4'b0100;
        step(); req_valid = '0;
        step(); reset_n = 1'b0; sb_q.delete();
        step(); reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("t5_no_rsp%0d", c), 32'(rsp_valid), 32'd0);
            step();
        end
        check("t5_op_count", 32'(op_count), 32'd0);
        req_valid = 4'b1111; #1;
        check("t5_ptr0", 32'(req_ready), 32'b0001);
        req_valid = '0;

        // 6: op_count wrap, single requester granted every cycle
        do_reset();
        step(); set_ops(99); req_valid = 4'b0001;
        repeat (65535) @(posedge clk);
        #1;
        check("t6_count_max", 32'(op_count), 32'hFFFF);
        check("t6_single_rdy", 32'(req_ready), 32'b0001);
        step(); req_valid = '0;
        check("t6_count_wrap", 32'(op_count), 32'h0000);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
